// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline result path: result record, serializer
// states and the data width.
package mips_pkg;

    localparam int DATA_W = 32;

    typedef struct packed {
        logic              fail;
        logic [DATA_W-1:0] out1;
        logic [DATA_W-1:0] out2;
        logic [DATA_W-1:0] out3;
    } mips_result_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2,
        W3   = 2'd3
    } ser_state_t;

endpackage

// File: rtl/mips_res_fifo.sv
// Synchronous FIFO of mips_result_t. A push is also accepted on a full FIFO
// when a pop happens on the same edge.
module mips_res_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  mips_result_t           i_data,
    output mips_result_t           o_head,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    mips_result_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // NOTE: storage has no reset; occupancy is tracked by pointers and level,
    // so stale contents are never presented as valid data.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/mips_result_serializer.sv
// Buffers pipeline results and streams them one 32-bit word per handshake.
// Optional failed-result counter: define MIPS_SER_FAIL_CNT_EN.
module mips_result_serializer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_fail,
    input  logic [DATA_W-1:0]      in_out1,
    input  logic [DATA_W-1:0]      in_out2,
    input  logic [DATA_W-1:0]      in_out3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_fail,
    output logic                   out_last,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
`ifdef MIPS_SER_FAIL_CNT_EN
    ,
    output logic [15:0]            fail_count
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;

    ser_state_t      r_state;
    ser_state_t      w_next_state;
    mips_result_t    w_in;
    mips_result_t    w_head;
    logic [LW-1:0]   w_level;
    logic            w_full;
    logic            w_empty;
    logic            w_hs;
    logic            w_pop;
    logic            w_push;
    logic            w_more;
    logic            r_overflow;

    assign w_in   = '{fail: in_fail, out1: in_out1, out2: in_out2, out3: in_out3};
    assign w_hs   = out_valid && out_ready;
    assign w_pop  = w_hs && out_last;
    assign w_push = in_valid && (!w_full || w_pop);
    // Another entry is present after this edge's pop (counting a same-edge push).
    assign w_more = (w_level > LW'(1)) || w_push;

    mips_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next_state = W1;
            W1:      if (w_hs) w_next_state = w_head.fail ? (w_more ? W1 : IDLE) : W2;
            W2:      if (w_hs) w_next_state = W3;
            W3:      if (w_hs) w_next_state = w_more ? W1 : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs depend only on state and FIFO head, never on out_ready.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_fail  = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            W1: begin
                out_valid = 1'b1;
                out_fail  = w_head.fail;
                out_last  = w_head.fail;
                out_data  = w_head.fail ? '0 : w_head.out1;
            end
            W2: begin
                out_valid = 1'b1;
                out_data  = w_head.out2;
            end
            W3: begin
                out_valid = 1'b1;
                out_data  = w_head.out3;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_overflow <= 1'b0;
        else if (in_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end

    assign overflow   = r_overflow;
    assign fifo_level = w_level;

`ifdef MIPS_SER_FAIL_CNT_EN
    logic [15:0] r_fail_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_count <= '0;
        end else if (w_push && in_fail && (r_fail_count != 16'hFFFF)) begin
            r_fail_count <= r_fail_count + 16'd1;
        end
    end

    assign fail_count = r_fail_count;
`endif

endmodule

// File: tb/tb_mips_result_serializer.sv
// Directed bench for mips_result_serializer (DEPTH=4); covers latency, failed
// entries, backpressure, overflow, full push/pop and mid-stream reset.
module tb_mips_result_serializer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_fail;
    logic [31:0] in_out1;
    logic [31:0] in_out2;
    logic [31:0] in_out3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_fail;
    logic        out_last;
    logic        overflow;
    logic [2:0]  fifo_level;
`ifdef MIPS_SER_FAIL_CNT_EN
    logic [15:0] fail_count;
`endif

    int n_cmp;
    int n_err;

    mips_result_serializer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_fail    (in_fail),
        .in_out1    (in_out1),
        .in_out2    (in_out2),
        .in_out3    (in_out3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_fail   (out_fail),
        .out_last   (out_last),
        .overflow   (overflow),
        .fifo_level (fifo_level)
`ifdef MIPS_SER_FAIL_CNT_EN
        ,
        .fail_count (fail_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c);
        in_valid = v;
        in_fail  = f;
        in_out1  = a;
        in_out2  = b;
        in_out3  = c;
    endtask

    // Checks the full idle/reset output picture as one packed vector.
    task automatic test_reset(input string tag);
        logic [38:0] got;
        got = {out_valid, out_fail, out_last, overflow, fifo_level, out_data};
        n_cmp++;
        if (got !== 39'd0) begin
            n_err++;
            $display("FAIL %s_outputs: got %h want 0", tag, got);
        end
`ifdef MIPS_SER_FAIL_CNT_EN
        n_cmp++;
        if (fail_count !== 16'd0) begin
            n_err++;
            $display("FAIL %s_fail_count: got %0d want 0", tag, fail_count);
        end
`endif
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 32'd1, 32'd2, 32'd3);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd1) begin
            n_err++;
            $display("FAIL single_after_e0: got valid=%b level=%0d want valid=0 level=1", out_valid, fifo_level);
        end
        step();
        for (int w = 1; w <= 3; w++) begin
            n_cmp++;
            if ({out_valid, out_fail, out_last, out_data} !== {1'b1, 1'b0, (w == 3), 32'(w)}) begin
                n_err++;
                $display("FAIL single_word%0d: got v=%b f=%b l=%b d=%h want v=1 f=0 l=%b d=%h",
                         w, out_valid, out_fail, out_last, out_data, (w == 3), 32'(w));
            end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL single_drained: got valid=%b level=%0d want 0/0", out_valid, fifo_level);
        end
    endtask

    task automatic test_fail_entry();
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 32'd5, 32'd6, 32'd7);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        step();
        n_cmp++;
        if ({out_valid, out_fail, out_last, out_data} !== {1'b1, 1'b1, 1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL fail_word: got v=%b f=%b l=%b d=%h want v=1 f=1 l=1 d=0",
                     out_valid, out_fail, out_last, out_data);
        end
`ifdef MIPS_SER_FAIL_CNT_EN
        n_cmp++;
        if (fail_count !== 16'd1) begin
            n_err++;
            $display("FAIL fail_count: got %0d want 1", fail_count);
        end
`endif
        step();
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL fail_drained: got valid=%b level=%0d want 0/0", out_valid, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 32'h10, 32'h20, 32'h30);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, out_last, out_data} !== {1'b1, 1'b0, 32'h20}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b l=%b d=%h want v=1 l=0 d=20",
                         i, out_valid, out_last, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        n_cmp++;
        if (out_data !== 32'h20) begin
            n_err++;
            $display("FAIL bp_still_w2: got %h want 20", out_data);
        end
        step();
        n_cmp++;
        if ({out_valid, out_last, out_data} !== {1'b1, 1'b1, 32'h30}) begin
            n_err++;
            $display("FAIL bp_resume_w3: got v=%b l=%b d=%h want v=1 l=1 d=30",
                     out_valid, out_last, out_data);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drained: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 32'(k * 256 + 1), 32'(k * 256 + 2), 32'(k * 256 + 3));
            step();
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        n_cmp++;
        if (fifo_level !== 3'd4 || out_data !== 32'h101) begin
            n_err++;
            $display("FAIL full_fill: got level=%0d d=%h want 4 / 101", fifo_level, out_data);
        end
        out_ready = 1'b1;
        step();
        step();
        drive(1'b1, 1'b0, 32'h501, 32'h502, 32'h503);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_pushpop: got level=%0d ovf=%b want 4 / 0", fifo_level, overflow);
        end
        for (int k = 2; k <= 5; k++) begin
            for (int w = 1; w <= 3; w++) begin
                n_cmp++;
                if ({out_valid, out_last, out_data} !== {1'b1, (w == 3), 32'(k * 256 + w)}) begin
                    n_err++;
                    $display("FAIL full_drain_e%0d_w%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                             k, w, out_valid, out_last, out_data, (w == 3), 32'(k * 256 + w));
                end
                step();
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL full_end: got v=%b level=%0d ovf=%b want 0/0/0", out_valid, fifo_level, overflow);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b0, 32'(k * 16 + 1), 32'(k * 16 + 2), 32'(k * 16 + 3));
            step();
            if (k == 4) begin
                n_cmp++;
                if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_at_full: got level=%0d ovf=%b want 4 / 0", fifo_level, overflow);
                end
            end
        end
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        n_cmp++;
        if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got level=%0d ovf=%b want 4 / 1", fifo_level, overflow);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            for (int w = 1; w <= 3; w++) begin
                n_cmp++;
                if ({out_valid, out_last, out_data} !== {1'b1, (w == 3), 32'(k * 16 + w)}) begin
                    n_err++;
                    $display("FAIL ovf_drain_e%0d_w%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                             k, w, out_valid, out_last, out_data, (w == 3), 32'(k * 16 + w));
                end
                step();
            end
        end
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_end: got v=%b level=%0d ovf=%b want 0/0/1", out_valid, fifo_level, overflow);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 32'hA1, 32'hA2, 32'hA3);
        step();
        drive(1'b1, 1'b0, 32'hB1, 32'hB2, 32'hB3);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        step();
        n_cmp++;
        if (out_data !== 32'hA2) begin
            n_err++;
            $display("FAIL rst_pre_w2: got %h want a2", out_data);
        end
        rst_n = 1'b0;
        #1;
        test_reset("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_queue_lost: got valid=%b want 0", out_valid);
        end
        drive(1'b1, 1'b0, 32'd7, 32'd8, 32'd9);
        step();
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        step();
        for (int w = 1; w <= 3; w++) begin
            n_cmp++;
            if ({out_valid, out_last, out_data} !== {1'b1, (w == 3), 32'(w + 6)}) begin
                n_err++;
                $display("FAIL rst_after_w%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h",
                         w, out_valid, out_last, out_data, (w == 3), 32'(w + 6));
            end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
            n_err++;
            $display("FAIL rst_after_end: got v=%b level=%0d want 0/0", out_valid, fifo_level);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        #12;
        test_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_single();
        test_fail_entry();
        test_backpressure();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
